pattern_load_sequencer: RTL
===========================

// Module: pattern_load_sequencer
// PURPOSE
//  Sequences one pattern-load run on the write side of the 256-bit sensor pattern FIFO.
//  On start it moves exactly num_pat words from the input pattern FIFO into the sensor FIFO.
//  It throttles on out_almost_full, then waits for the sensor FIFO to drain before signalling done.
//  Sits between the input pattern FIFO (read side) and the 256w->64r sensor FIFO (write side).
// PARAMETERS
//  DW  256  pattern word width, bits
//  CW  32   pattern counter width, bits
// PORTS
//  clk              in   1   write-side clock; all logic on posedge
//  reset            in   1   asynchronous, active-high reset
//  start            in   1   1-cycle pulse: begin run (ignored unless IDLE)
//  abort            in   1   1-cycle pulse: terminate run, return to IDLE
//  num_pat          in   CW  words to load; sampled on accepted start
//  pat_din          in   DW  input FIFO read data, valid when pat_valid=1
//  pat_empty        in   1   input FIFO empty
//  pat_valid        in   1   input FIFO read data valid (1 cycle after rd_en)
//  pat_rd_en        out  1   input FIFO read enable (combinational)
//  out_din          out  DW  sensor FIFO write data (registered)
//  out_wr_en        out  1   sensor FIFO write enable (registered)
//  out_almost_full  in   1   sensor FIFO almost full (threshold >= 2 words below full)
//  out_empty        in   1   sensor FIFO empty, already synchronised to clk
//  busy             out  1   high in LOAD and DRAIN
//  done             out  1   1-cycle pulse at run completion (not on abort)
//  words_written    out  CW  words written this run; cleared on accepted start
//  err_spurious     out  1   sticky: pat_valid with no read in flight; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; out_wr_en=0; out_din=0; busy=0; done=0; words_written=0; err_spurious=0; internal counters=0.
//  States:
//   IDLE:
//    - start & !abort: latch num_pat; clear issued, words_written, err_spurious.
//    - num_pat==0 -> DONE; else -> LOAD.
//   LOAD:
//    - pat_rd_en = !abort & !pat_empty & !out_almost_full & (issued < num_lat).
//    - issued increments on each pat_rd_en cycle; back-to-back reads allowed.
//    - words_written==num_lat -> DRAIN.
//   DRAIN: out_empty=1 -> DONE.
//   DONE: done=1 for exactly one cycle -> IDLE.
//  Datapath:
//   - pat_valid & inflight>0 & state!=IDLE: next cycle out_wr_en=1, out_din=pat_din, words_written+1.
//   - Latency from pat_valid to out_wr_en is 1 cycle.
//   - out_din holds its last value when out_wr_en=0.
//  Inflight tracking:
//   - inflight = issued minus words received; range 0..1 with a 1-cycle-latency FIFO.
//   - Tracked with a 2-bit counter.
//  Error: pat_valid while inflight==0, or while in IDLE -> word dropped, no write, err_spurious=1.
//  Abort (any state, including the same cycle as start):
//   - pat_rd_en forced 0 that cycle; state=IDLE next cycle; done not pulsed.
//   - A read already in flight completes: its word is discarded, not written.
//   - words_written holds the aborted-run value.
//  start while busy: ignored; no counter change.
//  Counters do not wrap: issued stops at num_lat; num_pat max = 2^CW-1.
//  out_almost_full may toggle at any time; reads pause and resume without loss or duplication.
// TESTING
//  - num_pat=4, FIFO pre-filled with A,B,C,D, out_almost_full=0 -> pat_rd_en high 4 consecutive cycles; out_wr_en 4 cycles carrying A..D; DRAIN; done pulses once out_empty=1; words_written=4.
//  - num_pat=0, start -> no pat_rd_en; done pulses 2 cycles after start; busy stays 0.
//  - num_pat=8, out_almost_full=1 after 3 words for 10 cycles -> exactly 8 writes, in order, none duplicated; pat_rd_en=0 while almost_full.
//  - num_pat=100, abort after 5 writes with a read in flight -> in-flight word not written; IDLE next cycle; words_written=5; done never pulses.
//  - pat_valid injected in IDLE -> err_spurious=1, no out_wr_en; next start clears it.
//  - start and abort in the same cycle, or start while busy -> state unchanged; num_lat not relatched.

Source files
------------

// File: rtl/pattern_load_sequencer.sv
// pattern_load_sequencer
//   Sequences one pattern-load run on the write side of the 256-bit sensor
//   pattern FIFO. A start pulse moves exactly num_pat words from the input
//   pattern FIFO into the sensor FIFO. Reads throttle on out_almost_full.
//   After the last write the block waits for the sensor FIFO to drain and
//   then pulses done.
//
// Ports
//   clk              in   write-side clock, all logic on posedge
//   reset            in   asynchronous active-high reset
//   start            in   1-cycle pulse, begins a run (accepted only in IDLE)
//   abort            in   1-cycle pulse, ends a run and returns to IDLE
//   num_pat          in   words to load, sampled on an accepted start
//   pat_din          in   input FIFO read data, valid when pat_valid=1
//   pat_empty        in   input FIFO empty
//   pat_valid        in   input FIFO read data valid (1 cycle after rd_en)
//   pat_rd_en        out  input FIFO read enable (combinational)
//   out_din          out  sensor FIFO write data (registered, held when idle)
//   out_wr_en        out  sensor FIFO write enable (registered)
//   out_almost_full  in   sensor FIFO almost full
//   out_empty        in   sensor FIFO empty, synchronised to clk
//   busy             out  high in LOAD and DRAIN
//   done             out  1-cycle pulse on run completion (never on abort)
//   words_written    out  words written this run, cleared on accepted start
//   err_spurious     out  sticky, pat_valid with no read in flight
module pattern_load_sequencer #(
    parameter int DW = 256,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_pat,
    input  logic [DW-1:0] pat_din,
    input  logic          pat_empty,
    input  logic          pat_valid,
    output logic          pat_rd_en,
    output logic [DW-1:0] out_din,
    output logic          out_wr_en,
    input  logic          out_almost_full,
    input  logic          out_empty,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] words_written,
    output logic          err_spurious
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] num_lat;
    logic [CW-1:0] issued;
    logic [1:0]    inflight;

    logic retire;
    logic take;
    logic spurious;

    always_comb begin
        pat_rd_en = (state == ST_LOAD) && !abort && !pat_empty &&
                    !out_almost_full && (issued < num_lat);
        // A returning word always retires its in-flight slot; it is only
        // written when the run is still live (an aborting cycle discards it).
        retire    = pat_valid && (inflight != 2'd0);
        take      = retire && (state != ST_IDLE) && !abort;
        spurious  = pat_valid && ((inflight == 2'd0) || (state == ST_IDLE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            num_lat       <= '0;
            issued        <= '0;
            inflight      <= '0;
            out_din       <= '0;
            out_wr_en     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            err_spurious  <= 1'b0;
        end else begin
            out_wr_en <= take;
            done      <= 1'b0;

            if (take) begin
                out_din       <= pat_din;
                words_written <= words_written + 1'b1;
            end

            if (pat_rd_en) begin
                issued <= issued + 1'b1;
            end

            case ({pat_rd_en, retire})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase

            unique case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        num_lat       <= num_pat;
                        issued        <= '0;
                        words_written <= '0;
                        err_spurious  <= 1'b0;
                        if (num_pat == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (words_written == num_lat) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_empty) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Sticky error set takes priority over the clear on start.
            if (spurious) begin
                err_spurious <= 1'b1;
            end

            if (abort) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end
        end
    end

endmodule
